// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_pkg
//  Description : Shared types, constants and helpers for the dmem arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package dmem_arbiter_pkg;

    // Two-state arbiter: choose a requester, then perform its memory access
    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_ACCESS = 1'b1
    } arb_state_t;

    localparam int XLEN = 32;

    // A byte address is word aligned when its two low bits are zero
    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage : dmem_arbiter_pkg
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_if
//  Description : Requester-side handshake plus dmem-side bus of the arbiter.
//                The slave modport is the arbiter; the master modport is the
//                environment (requesters and the data memory together).
//  Revision    : 1.0  initial release
// ============================================================================
interface dmem_arbiter_if #(
    parameter int NREQ = 2
) ();
    import dmem_arbiter_pkg::*;

    // Requester side
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      we;
    logic [NREQ*XLEN-1:0] addr;
    logic [NREQ*XLEN-1:0] wdata;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      rvalid;
    logic                 rerr;
    logic [XLEN-1:0]      rdata;

    // Data memory side
    logic                 mem_we;
    logic [XLEN-1:0]      mem_addr;
    logic [XLEN-1:0]      mem_wd;
    logic [XLEN-1:0]      mem_rd;

    modport slave (
        input  req, we, addr, wdata, mem_rd,
        output gnt, rvalid, rerr, rdata, mem_we, mem_addr, mem_wd
    );

    modport master (
        output req, we, addr, wdata, mem_rd,
        input  gnt, rvalid, rerr, rdata, mem_we, mem_addr, mem_wd
    );

endinterface : dmem_arbiter_if
`default_nettype wire

// File: rtl/dmem_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Returns a one-hot grant for
//                the first asserted request at or above the pointer, with
//                wrap-around, plus a flag telling whether anything requested.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  wire logic [NREQ-1:0]  i_req,
    input  wire logic [PTR_W-1:0] i_ptr,
    output logic      [NREQ-1:0]  o_grant,
    output logic                  o_any
);

    // Walk the priority order ptr, ptr+1, ... and grant the first requester found
    always_comb begin
        o_grant = '0;
        o_any   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!o_any && i_req[i] && (((int'(i_ptr) + k) % NREQ) == i)) begin
                    o_any      = 1'b1;
                    o_grant[i] = 1'b1;
                end
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Round-robin arbiter sharing one single-port data memory among
//                NREQ requesters. One transaction per two cycles: IDLE picks
//                and latches a command, ACCESS drives memory and registers the
//                response. Misaligned or out-of-range accesses get an error
//                response and never touch memory.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int DEPTH = 64
) (
    input  wire logic      clk,
    input  wire logic      reset,
    dmem_arbiter_if.slave  bus
);

    localparam int                PTR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [XLEN-3:0]   c_DEPTH = (XLEN-2)'(DEPTH);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [PTR_W-1:0]  r_ptr;
    logic [PTR_W-1:0]  w_ptr_nxt;
    logic [NREQ-1:0]   r_owner_oh;
    logic              r_we;
    logic [XLEN-1:0]   r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [NREQ-1:0]   r_rvalid;
    logic              r_rerr;
    logic [XLEN-1:0]   r_rdata;

    logic [NREQ-1:0]   w_grant;
    logic              w_any;
    logic              w_sel_we;
    logic [XLEN-1:0]   w_sel_addr;
    logic [XLEN-1:0]   w_sel_wdata;
    logic              w_legal;
    logic [NREQ-1:0]   w_gnt;
    logic              w_mem_we;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_any   (w_any)
    );

    // Route the winning requester's command and compute the pointer after it
    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_ptr_nxt   = r_ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_we    = bus.we[i];
                w_sel_addr  = bus.addr[i*XLEN +: XLEN];
                w_sel_wdata = bus.wdata[i*XLEN +: XLEN];
                w_ptr_nxt   = (i == NREQ-1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    // The latched command is legal when word aligned and inside the memory
    assign w_legal = is_word_aligned(r_addr) && (r_addr[XLEN-1:2] < c_DEPTH);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the outputs decoded from the registered state;
    // reset gates the write strobe so an aborted write is suppressed at once
    always_comb begin
        w_state_nxt = r_state;
        w_gnt       = '0;
        w_mem_we    = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                w_state_nxt = ARB_IDLE;
                w_gnt       = r_owner_oh;
                w_mem_we    = r_we && w_legal && !reset;
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    // Command latch on arbitration, response register at the end of ACCESS
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr      <= '0;
            r_owner_oh <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rvalid   <= '0;
            r_rerr     <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_rvalid <= '0;
            if ((r_state == ARB_IDLE) && w_any) begin
                r_we       <= w_sel_we;
                r_addr     <= w_sel_addr;
                r_wdata    <= w_sel_wdata;
                r_owner_oh <= w_grant;
                r_ptr      <= w_ptr_nxt;
            end
            if (r_state == ARB_ACCESS) begin
                r_rvalid <= r_owner_oh;
                if (w_legal) begin
                    r_rerr  <= 1'b0;
                    r_rdata <= r_we ? '0 : bus.mem_rd;
                end else begin
                    r_rerr  <= 1'b1;
                    r_rdata <= '0;
                end
            end
        end
    end

    assign bus.gnt      = w_gnt;
    assign bus.rvalid   = r_rvalid;
    assign bus.rerr     = r_rerr;
    assign bus.rdata    = r_rdata;
    assign bus.mem_we   = w_mem_we;
    assign bus.mem_addr = r_addr;
    assign bus.mem_wd   = r_wdata;

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter: directed scenarios then
//                randomized traffic against a transaction-level reference.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int NREQ  = 2;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.NREQ(NREQ)) bus ();

    dmem_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Behavioural data memory with combinational read
    logic [31:0] tb_mem [DEPTH];
    logic        ld_en = 1'b0;
    logic [5:0]  ld_idx = '0;
    logic [31:0] ld_val = '0;
    assign bus.mem_rd = (bus.mem_addr < 32'd256) ? tb_mem[bus.mem_addr[7:2]] : 32'hBAD0_BAD0;
    always @(posedge clk) begin
        if (ld_en) tb_mem[ld_idx] <= ld_val;
        else if (bus.mem_we) tb_mem[bus.mem_addr[7:2]] <= bus.mem_wd;
    end

    // Requester-side stimulus state
    logic [NREQ-1:0] v_req = '0;
    logic [NREQ-1:0] v_we  = '0;
    logic [31:0]     v_addr  [NREQ];
    logic [31:0]     v_wdata [NREQ];

    // Reference model state
    logic [31:0] ref_mem [DEPTH];
    bit          m_busy;
    int          m_owner, m_ptr;
    int          waitc [NREQ];
    logic        p_rerr;
    logic [31:0] p_rdata;

    int vectors = 0;
    int miscompares = 0;
    int gq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        bus.req = v_req;
        bus.we  = v_we;
        for (int i = 0; i < NREQ; i++) begin
            bus.addr[i*32 +: 32]  = v_addr[i];
            bus.wdata[i*32 +: 32] = v_wdata[i];
        end
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
            1:       return 32'(256 + $urandom_range(0, 1000) * 4);
            default: return 32'($urandom_range(0, 15) * 4);
        endcase
    endfunction

    task automatic new_cmd(input int i);
        v_req[i]   = 1'b1;
        v_we[i]    = 1'($urandom_range(0, 1));
        v_addr[i]  = rand_addr();
        v_wdata[i] = $urandom();
    endtask

    task automatic model_reset();
        m_busy = 0;
        m_ptr  = 0;
        for (int i = 0; i < NREQ; i++) waitc[i] = 0;
    endtask

    // One clock: predict from the rules, advance, compare
    task automatic step();
        logic [NREQ-1:0] e_gnt, e_rv;
        logic            e_mwe, e_rerr, legal;
        logic [31:0]     e_rdata, e_maddr, e_mwd;
        int              w;
        apply();
        e_gnt = '0; e_rv = '0; e_mwe = 1'b0; e_rerr = 1'b0;
        e_rdata = '0; e_maddr = '0; e_mwd = '0;
        for (int i = 0; i < NREQ; i++) if (!v_req[i]) waitc[i] = 0;
        if (m_busy) begin
            e_rv[m_owner] = 1'b1;
            e_rerr  = p_rerr;
            e_rdata = p_rdata;
            m_busy  = 0;
        end else if (|v_req) begin
            w = -1;
            for (int k = 0; k < NREQ; k++)
                if (w < 0 && v_req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            for (int i = 0; i < NREQ; i++) if (i != w && v_req[i]) waitc[i]++;
            chk("fairness_wait_ok", 32'(waitc[w] <= NREQ - 1), 32'd1);
            waitc[w] = 0;
            legal    = (v_addr[w] % 4 == 0) && (v_addr[w] / 4 < DEPTH);
            e_gnt[w] = 1'b1;
            e_mwe    = legal && v_we[w];
            e_maddr  = v_addr[w];
            e_mwd    = v_wdata[w];
            p_rerr   = !legal;
            p_rdata  = (legal && !v_we[w]) ? ref_mem[v_addr[w] / 4] : 32'h0;
            if (legal && v_we[w]) ref_mem[v_addr[w] / 4] = v_wdata[w];
            m_busy  = 1;
            m_owner = w;
            m_ptr   = (w + 1) % NREQ;
        end
        @(posedge clk);
        #1;
        chk("gnt", 32'(bus.gnt), 32'(e_gnt));
        chk("rvalid", 32'(bus.rvalid), 32'(e_rv));
        chk("mem_we", 32'(bus.mem_we), 32'(e_mwe));
        if (e_gnt != '0) begin
            chk("mem_addr", bus.mem_addr, e_maddr);
            chk("mem_wd", bus.mem_wd, e_mwd);
        end
        if (e_rv != '0) begin
            chk("rerr", 32'(bus.rerr), 32'(e_rerr));
            chk("rdata", bus.rdata, e_rdata);
        end
    endtask

    // Step until every requester has been served and its response seen
    task automatic run_until_idle(input int maxc);
        for (int c = 0; c < maxc; c++) begin
            step();
            for (int i = 0; i < NREQ; i++) if (bus.gnt[i]) v_req[i] = 1'b0;
            if (v_req == '0 && !m_busy) break;
        end
        chk("drain_done", {31'd0, (m_busy || (v_req != '0))}, 32'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
        chk({tag, "_rvalid"}, 32'(bus.rvalid), 32'd0);
        chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
        chk({tag, "_rerr"}, 32'(bus.rerr), 32'd0);
        chk({tag, "_rdata"}, bus.rdata, 32'd0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
        chk({tag, "_mem_wd"}, bus.mem_wd, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        v_req = '0;
        apply();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check_zero("reset");
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            v_addr[i] = '0;
            v_wdata[i] = '0;
        end
        model_reset();
        apply();
        // Preload memory while reset is held
        for (int i = 0; i < DEPTH; i++) begin
            ld_en  = 1'b1;
            ld_idx = 6'(i);
            ld_val = (i == 5) ? 32'hDEAD_BEEF : $urandom();
            ref_mem[i] = ld_val;
            @(posedge clk);
            #1;
        end
        ld_en = 1'b0;
        do_reset();

        // Single read of word 5
        v_req = 2'b01; v_we[0] = 1'b0; v_addr[0] = 32'h14;
        run_until_idle(10);
        chk("t1_rdata", bus.rdata, 32'hDEAD_BEEF);
        chk("t1_rerr", 32'(bus.rerr), 32'd0);

        // Request raised in the cycle right after rvalid
        v_req = 2'b10; v_we[1] = 1'b0; v_addr[1] = 32'h14;
        run_until_idle(10);

        // Port 1 writes then reads back, next command presented after gnt
        v_req = 2'b10; v_we[1] = 1'b1; v_addr[1] = 32'h08; v_wdata[1] = 32'h1234_5678;
        step();
        v_we[1] = 1'b0;
        run_until_idle(10);
        chk("t2_readback", bus.rdata, 32'h1234_5678);

        // Contention from reset: both ports request continuously
        do_reset();
        new_cmd(0);
        new_cmd(1);
        gq.delete();
        for (int c = 0; c < 8; c++) begin
            step();
            for (int i = 0; i < NREQ; i++)
                if (bus.gnt[i]) begin
                    gq.push_back(i);
                    new_cmd(i);
                end
        end
        chk("t3_ngrants", 32'(gq.size()), 32'd4);
        for (int k = 0; k < 4 && k < gq.size(); k++)
            chk("t3_order", 32'(gq[k]), 32'(k % 2));
        run_until_idle(10);

        // Error accesses: misaligned read and write to word DEPTH
        v_req = 2'b11;
        v_we[0] = 1'b0; v_addr[0] = 32'h102;
        v_we[1] = 1'b1; v_addr[1] = 32'h100; v_wdata[1] = 32'hCAFE_F00D;
        run_until_idle(12);
        chk("t4_rerr_hold", 32'(bus.rerr), 32'd1);
        chk("t4_rdata_hold", bus.rdata, 32'd0);

        // Reset asserted during the ACCESS cycle of a write
        v_req = 2'b01; v_we[0] = 1'b1; v_addr[0] = 32'h0C; v_wdata[0] = 32'hA5A5_A5A5;
        step();
        reset = 1'b1;
        v_req = '0;
        apply();
        #1;
        chk("t5_mem_we_in_reset", 32'(bus.mem_we), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        ref_mem[3] = tb_mem[3];
        check_zero("t5");
        step();
        chk("t5_no_late_rvalid", 32'(bus.rvalid), 32'd0);
        v_req = 2'b11; v_we = 2'b00; v_addr[0] = 32'h0C; v_addr[1] = 32'h10;
        run_until_idle(12);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (bus.gnt[i]) begin
                    if ($urandom_range(0, 1) == 1) new_cmd(i);
                    else v_req[i] = 1'b0;
                end else if (!v_req[i] && $urandom_range(0, 2) == 0) begin
                    new_cmd(i);
                end
            end
        end
        run_until_idle(12);
        step();

        for (int i = 0; i < DEPTH; i++) chk("final_mem", tb_mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_dmem_arbiter
`default_nettype wire
